// File: rtl/jvm_fetch_pkg.sv
// rtl/jvm_fetch_pkg.sv - shared constants for the JVM bytecode fetch unit
//
// Purpose: fetch FSM state encodings and the width of a prefetch FIFO entry
// (one bytecode plus the PC it was read from).
package jvm_fetch_pkg;

  localparam logic [1:0] FETCH_IDLE  = 2'd0;
  localparam logic [1:0] FETCH_ISSUE = 2'd1;
  localparam logic [1:0] FETCH_BUSY  = 2'd2;

  localparam int BYTE_WIDTH = 8;

  // Entry layout is {bytecode, pc}; the PC width follows ADDRESS_WIDTH.
  function automatic int entry_width(input int address_width);
    return BYTE_WIDTH + address_width;
  endfunction

endpackage

// File: rtl/jvm_fetch_fifo.sv
// rtl/jvm_fetch_fifo.sv - prefetch FIFO for fetched bytecodes
//
// Purpose: synchronous FIFO of DEPTH entries with flush. The head entry is
// presented combinationally from storage.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   flush           empties the FIFO at the next edge; beats push and pop
//   push, push_data write one entry
//   pop             remove the head entry (ignored while empty)
//   head_data       entry at the head
//   count           number of stored entries
//   empty, full     occupancy flags
module jvm_fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = storage[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/jvm_bytecode_fetch.sv
// rtl/jvm_bytecode_fetch.sv - bytecode fetch unit with prefetch FIFO and redirect
//
// Purpose: walks a fetch PC, reads one byte at a time from the byte-wide JVM
// memory (start/ready/rwn handshake), buffers {byte, pc} in a prefetch FIFO
// and hands one bytecode per cycle to the decoder. A redirect flushes the
// FIFO and restarts fetching at a new PC.
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   fetch_en                     permits new memory reads
//   redirect_valid, redirect_pc  one-cycle branch/redirect request
//   op_valid, op_byte, op_pc     head bytecode and its address
//   op_ready                     decoder takes the head entry
//   mem_address, mem_data_in,
//   mem_rwn, mem_start           memory request side (read only)
//   mem_ready, mem_data_out      memory idle / read data
module jvm_bytecode_fetch
  import jvm_fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 8,
  parameter int                       DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     op_valid,
  output logic [BYTE_WIDTH-1:0]    op_byte,
  output logic [ADDRESS_WIDTH-1:0] op_pc,
  input  logic                     op_ready,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [BYTE_WIDTH-1:0]    mem_data_in,
  output logic                     mem_rwn,
  output logic                     mem_start,
  input  logic                     mem_ready,
  input  logic [BYTE_WIDTH-1:0]    mem_data_out
);

  localparam int EW = entry_width(ADDRESS_WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]               state;
  logic [1:0]               state_next;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [ADDRESS_WIDTH-1:0] req_pc;
  logic                     drop;

  logic [CW-1:0]            count;
  logic                     empty;
  logic                     full;
  logic [EW-1:0]            head;

  logic                     in_flight;
  logic [CW-1:0]            occupancy;
  logic                     can_issue;
  logic                     complete;
  logic                     push;
  logic                     pop;

  // Reserving a slot for the outstanding read keeps the FIFO from overflowing.
  assign in_flight = (state != FETCH_IDLE);
  assign occupancy = count + CW'(in_flight);
  assign can_issue = fetch_en && mem_ready && !redirect_valid && !full &&
                     (occupancy < CW'(DEPTH));
  assign complete  = (state == FETCH_BUSY) && mem_ready;
  assign push      = complete && !drop;
  assign pop       = op_valid && op_ready;

  always_comb begin
    state_next = state;
    case (state)
      FETCH_IDLE:  if (can_issue) state_next = FETCH_ISSUE;
      FETCH_ISSUE: state_next = FETCH_BUSY;
      FETCH_BUSY:  if (mem_ready) state_next = can_issue ? FETCH_ISSUE : FETCH_IDLE;
      default:     state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      drop     <= 1'b0;
    end else begin
      state <= state_next;

      if (redirect_valid)            fetch_pc <= redirect_pc;
      else if (state == FETCH_ISSUE) fetch_pc <= fetch_pc + 1'b1;

      if (state == FETCH_ISSUE) req_pc <= fetch_pc;

      // A read that completes in the redirect cycle is already killed by the
      // flush, so drop is only armed for reads that finish later.
      if (redirect_valid && ((state == FETCH_ISSUE) || ((state == FETCH_BUSY) && !mem_ready)))
        drop <= 1'b1;
      else if (complete)
        drop <= 1'b0;
    end
  end

  jvm_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({mem_data_out, req_pc}),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign op_valid    = !empty;
  assign op_byte     = head[EW-1:ADDRESS_WIDTH];
  assign op_pc       = head[ADDRESS_WIDTH-1:0];

  assign mem_start   = (state == FETCH_ISSUE);
  assign mem_address = fetch_pc;
  assign mem_data_in = '0;
  assign mem_rwn     = 1'b1;

endmodule

// File: tb/tb_jvm_bytecode_fetch.sv
// tb/tb_jvm_bytecode_fetch.sv - self-checking bench for jvm_bytecode_fetch
module tb_jvm_bytecode_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] mem [256];
  int         lat;

  logic       fetch_en_a, redirect_valid_a, op_ready_a, op_valid_a;
  logic [7:0] redirect_pc_a, op_byte_a, op_pc_a, mem_address_a, mem_data_in_a, mem_data_out_a;
  logic       mem_rwn_a, mem_start_a, mem_ready_a;
  logic [7:0] lat_cnt_a, addr_l_a;

  logic       fetch_en_b, redirect_valid_b, op_ready_b, op_valid_b;
  logic [7:0] redirect_pc_b, op_byte_b, op_pc_b, mem_address_b, mem_data_in_b, mem_data_out_b;
  logic       mem_rwn_b, mem_start_b, mem_ready_b;
  logic [7:0] lat_cnt_b, addr_l_b;

  jvm_bytecode_fetch #(.ADDRESS_WIDTH(8), .DEPTH(4), .RESET_PC(8'd0)) dut_a (
    .clk(clk), .reset(reset), .fetch_en(fetch_en_a),
    .redirect_valid(redirect_valid_a), .redirect_pc(redirect_pc_a),
    .op_valid(op_valid_a), .op_byte(op_byte_a), .op_pc(op_pc_a), .op_ready(op_ready_a),
    .mem_address(mem_address_a), .mem_data_in(mem_data_in_a), .mem_rwn(mem_rwn_a),
    .mem_start(mem_start_a), .mem_ready(mem_ready_a), .mem_data_out(mem_data_out_a));

  jvm_bytecode_fetch #(.ADDRESS_WIDTH(8), .DEPTH(4), .RESET_PC(8'd254)) dut_b (
    .clk(clk), .reset(reset), .fetch_en(fetch_en_b),
    .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
    .op_valid(op_valid_b), .op_byte(op_byte_b), .op_pc(op_pc_b), .op_ready(op_ready_b),
    .mem_address(mem_address_b), .mem_data_in(mem_data_in_b), .mem_rwn(mem_rwn_b),
    .mem_start(mem_start_b), .mem_ready(mem_ready_b), .mem_data_out(mem_data_out_b));

  // Byte memory models: ready drops the cycle after start, rises lat+1 cycles later with data.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_ready_a <= 1'b1; lat_cnt_a <= 8'd0; addr_l_a <= 8'd0; mem_data_out_a <= 8'd0;
    end else if (mem_ready_a && mem_start_a) begin
      mem_ready_a <= 1'b0; lat_cnt_a <= 8'(lat); addr_l_a <= mem_address_a;
    end else if (!mem_ready_a) begin
      if (lat_cnt_a == 8'd0) begin mem_ready_a <= 1'b1; mem_data_out_a <= mem[addr_l_a]; end
      else lat_cnt_a <= lat_cnt_a - 8'd1;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_ready_b <= 1'b1; lat_cnt_b <= 8'd0; addr_l_b <= 8'd0; mem_data_out_b <= 8'd0;
    end else if (mem_ready_b && mem_start_b) begin
      mem_ready_b <= 1'b0; lat_cnt_b <= 8'(lat); addr_l_b <= mem_address_b;
    end else if (!mem_ready_b) begin
      if (lat_cnt_b == 8'd0) begin mem_ready_b <= 1'b1; mem_data_out_b <= mem[addr_l_b]; end
      else lat_cnt_b <= lat_cnt_b - 8'd1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] got_pc_a[$], got_byte_a[$], got_pc_b[$], got_byte_b[$];

  typedef struct {
    logic [7:0] rpc;
    int         lat;
    logic [7:0] pc0, b0, pc1, b1;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with inputs set: logs entries taken at the coming edge, then advances.
  task automatic step();
    if (reset && op_valid_a && op_ready_a && !redirect_valid_a) begin
      got_pc_a.push_back(op_pc_a); got_byte_a.push_back(op_byte_a);
    end
    if (reset && op_valid_b && op_ready_b && !redirect_valid_b) begin
      got_pc_b.push_back(op_pc_b); got_byte_b.push_back(op_byte_b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic collect_a(input int n, input string name);
    int k = 0;
    while (got_pc_a.size() < n && k < 300) begin step(); k++; end
    check({name, " entries"}, 32'(got_pc_a.size() >= n), 32'd1);
  endtask

  task automatic expect_a(input int i, input string name, input logic [7:0] pc, input logic [7:0] b);
    check($sformatf("%s op_pc[%0d]", name, i), (i < got_pc_a.size()) ? 32'(got_pc_a[i]) : 32'hDEAD, 32'(pc));
    check($sformatf("%s op_byte[%0d]", name, i), (i < got_byte_a.size()) ? 32'(got_byte_a[i]) : 32'hDEAD, 32'(b));
  endtask

  task automatic drain_a();
    fetch_en_a = 1'b0;
    op_ready_a = 1'b1;
    repeat (20) step();
    got_pc_a.delete(); got_byte_a.delete();
  endtask

  task automatic redirect_a(input logic [7:0] pc);
    redirect_valid_a = 1'b1; redirect_pc_a = pc;
    step();
    redirect_valid_a = 1'b0;
  endtask

  task automatic wait_a(input string name, input int what);
    int k = 0;
    logic hit;
    hit = 1'b0;
    while (!hit && k < 200) begin
      case (what)
        0:       hit = op_valid_a;
        1:       hit = !mem_ready_a;
        default: hit = mem_ready_a;
      endcase
      if (!hit) begin step(); k++; end
    end
    check({name, " reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    int k;
    int starts;
    reset = 1'b0; lat = 1;
    fetch_en_a = 0; redirect_valid_a = 0; redirect_pc_a = 0; op_ready_a = 0;
    fetch_en_b = 0; redirect_valid_b = 0; redirect_pc_b = 0; op_ready_b = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 9; i++) mem[i] = 8'h10 + 8'(i);
    mem[8'h40] = 8'h5A; mem[8'h41] = 8'h5B; mem[254] = 8'hAA; mem[255] = 8'hBB;

    vecs[0] = '{8'h40, 1, 8'h40, 8'h5A, 8'h41, 8'h5B};
    vecs[1] = '{8'h80, 0, 8'h80, 8'h25, 8'h81, 8'h24};
    vecs[2] = '{8'hFE, 2, 8'hFE, 8'hAA, 8'hFF, 8'hBB};
    vecs[3] = '{8'hFF, 3, 8'hFF, 8'hBB, 8'h00, 8'h10};
    vecs[4] = '{8'h20, 1, 8'h20, 8'h85, 8'h21, 8'h84};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset op_valid", 32'(op_valid_a), 32'd0);
    check("reset mem_start", 32'(mem_start_a), 32'd0);
    check("reset mem_address", 32'(mem_address_a), 32'd0);
    check("reset mem_address b", 32'(mem_address_b), 32'd254);
    check("mem_rwn", 32'(mem_rwn_a & mem_rwn_b), 32'd1);
    check("mem_data_in", 32'(mem_data_in_a | mem_data_in_b), 32'd0);
    reset = 1'b1;
    step();

    // Sequential fetch from PC 0
    lat = 1; fetch_en_a = 1; op_ready_a = 1;
    collect_a(4, "seq");
    for (int i = 0; i < 4; i++) expect_a(i, "seq", 8'(i), 8'h10 + 8'(i));
    drain_a();

    // Back-pressure: exactly four entries buffered, then ordered drain and resume
    redirect_a(8'h04);
    op_ready_a = 0; fetch_en_a = 1;
    repeat (60) step();
    starts = 0;
    repeat (20) begin if (mem_start_a) starts++; step(); end
    check("bp mem_start while full", 32'(starts), 32'd0);
    check("bp head op_pc", 32'(op_pc_a), 32'h04);
    check("bp head op_byte", 32'(op_byte_a), 32'h14);
    op_ready_a = 1;
    repeat (5) step();
    check("bp buffered count", 32'(got_pc_a.size()), 32'd4);
    collect_a(5, "bp");
    for (int i = 0; i < 5; i++) expect_a(i, "bp", 8'h04 + 8'(i), 8'h14 + 8'(i));
    drain_a();

    // Redirect table with varying memory latency
    foreach (vecs[v]) begin
      lat = vecs[v].lat; fetch_en_a = 1; op_ready_a = 1;
      redirect_a(vecs[v].rpc);
      collect_a(2, $sformatf("vec%0d", v));
      expect_a(0, $sformatf("vec%0d", v), vecs[v].pc0, vecs[v].b0);
      expect_a(1, $sformatf("vec%0d", v), vecs[v].pc1, vecs[v].b1);
      drain_a();
    end

    // Redirect while the read of PC 2 is in flight
    lat = 1; fetch_en_a = 1; op_ready_a = 1;
    redirect_a(8'h00);
    k = 0;
    while (!(mem_start_a && mem_address_a == 8'd2) && k < 100) begin step(); k++; end
    check("busy issue pc2 reached", 32'(mem_start_a && mem_address_a == 8'd2), 32'd1);
    step();
    got_pc_a.delete(); got_byte_a.delete();
    redirect_a(8'h40);
    collect_a(2, "busy");
    expect_a(0, "busy", 8'h40, 8'h5A);
    expect_a(1, "busy", 8'h41, 8'h5B);
    drain_a();

    // Push, pop and redirect in the same cycle
    lat = 2; fetch_en_a = 1; op_ready_a = 0;
    redirect_a(8'h10);
    wait_a("sim op_valid", 0);
    wait_a("sim busy", 1);
    wait_a("sim complete", 2);
    check("sim fifo holds entry", 32'(op_valid_a), 32'd1);
    op_ready_a = 1;
    redirect_a(8'h80);
    check("sim op_valid after redirect", 32'(op_valid_a), 32'd0);
    check("sim fetch_pc", 32'(mem_address_a), 32'h80);
    collect_a(1, "sim");
    expect_a(0, "sim", 8'h80, 8'h25);
    drain_a();

    // Reset while a read is outstanding
    lat = 2; fetch_en_a = 1; op_ready_a = 0;
    redirect_a(8'h20);
    wait_a("rst op_valid", 0);
    wait_a("rst busy", 1);
    reset = 1'b0;
    #1;
    check("rst op_valid", 32'(op_valid_a), 32'd0);
    check("rst mem_start", 32'(mem_start_a), 32'd0);
    check("rst mem_address", 32'(mem_address_a), 32'd0);
    @(negedge clk);
    step();
    got_pc_a.delete(); got_byte_a.delete();
    reset = 1'b1; op_ready_a = 1;
    collect_a(1, "rst");
    expect_a(0, "rst", 8'h00, 8'h10);
    drain_a();

    // Wrap-around from RESET_PC 254
    mem[0] = 8'hCC; lat = 1;
    fetch_en_b = 1; op_ready_b = 1;
    k = 0;
    while (got_pc_b.size() < 3 && k < 200) begin step(); k++; end
    check("wrap entries", 32'(got_pc_b.size() >= 3), 32'd1);
    if (got_pc_b.size() >= 3) begin
      check("wrap op_pc[0]", 32'(got_pc_b[0]), 32'd254);
      check("wrap op_byte[0]", 32'(got_byte_b[0]), 32'hAA);
      check("wrap op_pc[1]", 32'(got_pc_b[1]), 32'd255);
      check("wrap op_byte[1]", 32'(got_byte_b[1]), 32'hBB);
      check("wrap op_pc[2]", 32'(got_pc_b[2]), 32'd0);
      check("wrap op_byte[2]", 32'(got_byte_b[2]), 32'hCC);
    end
    fetch_en_b = 0;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
